edge_event_receiver: RTL and testbench

Destination-side consumer for single-cycle or stretched event pulses produced by the team's edge synchronizers. It detects each pulse start, queues events in a saturating pending counter, and presents them to downstream logic through a valid/ready handshake. It also checks every pulse against the expected width and raises sticky error flags for pulse-width mismatches and queue overflows. The block sits entirely in the destination clock domain, directly after the synchronizer output.

---
 rtl/edge_event_pkg.sv | 15 +
 rtl/event_pending_counter.sv | 40 ++++
 rtl/edge_event_receiver.sv | 126 ++++++++++++
 tb/tb_edge_event_receiver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_event_pkg.sv
// Shared types and sizing helpers for the edge event receiver.
package edge_event_pkg;

    // Pulse-width measurement FSM states.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } width_state_e;

    // Number of bits needed to hold values 0..n inclusive.
    function automatic int count_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/event_pending_counter.sv
// Up/down saturating counter of pending events. An increment while full is
// dropped and reported by a single-cycle overflow pulse. A simultaneous
// increment and decrement leaves the count unchanged, even when full.
module event_pending_counter
    import edge_event_pkg::*;
#(
    parameter int MaxPending = 15
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                inc,
    input  logic                                dec,
    output logic [count_bits(MaxPending)-1:0]   count,
    output logic                                full,
    output logic                                overflow
);

    localparam int CW = count_bits(MaxPending);

    logic [CW-1:0] count_reg;
    logic          dec_eff;

    // A decrement on an empty counter is meaningless and is ignored.
    assign dec_eff  = dec & (count_reg != '0);
    assign full     = (count_reg == CW'(MaxPending));
    assign overflow = inc & ~dec_eff & full;
    assign count    = count_reg;

    // Count register: increment unless full, decrement unless empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg <= '0;
        end else if (inc && !dec_eff && !full) begin
            count_reg <= count_reg + 1'b1;
        end else if (dec_eff && !inc) begin
            count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/edge_event_receiver.sv
// Destination-side event receiver: detects pulse starts, queues them in a
// saturating pending counter behind a valid/ready handshake, and flags
// pulse-width mismatches and dropped events with sticky error bits.
module edge_event_receiver
    import edge_event_pkg::*;
#(
    parameter int PulseWidth = 1,
    parameter int MaxPending = 15
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                pulse_i,
    output logic                                event_valid_o,
    input  logic                                event_ready_i,
    output logic [count_bits(MaxPending)-1:0]   pending_o,
    output logic                                overflow_o,
    output logic                                width_err_o,
    input  logic                                clear_i
);

    localparam int WCW = count_bits(PulseWidth + 1);
    localparam logic [WCW-1:0] CNT_EXP = WCW'(PulseWidth);
    localparam logic [WCW-1:0] CNT_SAT = WCW'(PulseWidth + 1);

    if (PulseWidth < 1) begin : g_bad_pulse_width
        $error("edge_event_receiver: PulseWidth must be >= 1");
    end
    if (MaxPending < 1) begin : g_bad_max_pending
        $error("edge_event_receiver: MaxPending must be >= 1");
    end

    logic           pulse_d_reg;
    logic           rise;
    logic           pop;
    width_state_e   state_reg, state_next;
    logic [WCW-1:0] width_cnt_reg, width_cnt_next;
    logic           width_set;
    logic           width_err_reg;
    logic           overflow_reg;
    logic           queue_full;
    logic           ovf_pulse;
    logic [count_bits(MaxPending)-1:0] pending;

    assign rise          = pulse_i & ~pulse_d_reg;
    // Valid comes from the pending register alone; ready never feeds it.
    assign event_valid_o = (pending != '0);
    assign pop           = event_valid_o & event_ready_i;

    event_pending_counter #(
        .MaxPending (MaxPending)
    ) u_pending (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .inc      (rise),
        .dec      (pop),
        .count    (pending),
        .full     (queue_full),
        .overflow (ovf_pulse)
    );

    // Previous-cycle pulse sample for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pulse_d_reg <= 1'b0;
        end else begin
            pulse_d_reg <= pulse_i;
        end
    end

    // Width FSM state and width counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            width_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            width_cnt_reg <= width_cnt_next;
        end
    end

    // Width FSM: count high cycles from the rise, judge the width on the low.
    always_comb begin
        state_next     = state_reg;
        width_cnt_next = width_cnt_reg;
        width_set      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next     = MEASURE;
                    width_cnt_next = WCW'(1);
                end
            end
            MEASURE: begin
                if (pulse_i) begin
                    // Saturate one past the expected width: any longer pulse
                    // is already known to be wrong.
                    if (width_cnt_reg != CNT_SAT) begin
                        width_cnt_next = width_cnt_reg + 1'b1;
                    end
                end else begin
                    width_set  = (width_cnt_reg != CNT_EXP);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as clear_i takes priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            width_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            width_err_reg <= width_set | (width_err_reg & ~clear_i);
            // The counter only pulses overflow while full; the AND makes
            // that dependency explicit at this level.
            overflow_reg  <= (ovf_pulse & queue_full) | (overflow_reg & ~clear_i);
        end
    end

    assign pending_o   = pending;
    assign width_err_o = width_err_reg;
    assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_edge_event_receiver.sv
// Self-checking bench for edge_event_receiver. Two instances share stimulus:
// inst A (PulseWidth=1, MaxPending=15) and inst B (PulseWidth=4, MaxPending=3).
module tb_edge_event_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, pulse, ready, clear;

    logic       valid_a, ovf_a, err_a;
    logic [3:0] pend_a;
    logic       valid_b, ovf_b, err_b;
    logic [1:0] pend_b;

    int checks = 0;
    int errors = 0;

    edge_event_receiver #(.PulseWidth(1), .MaxPending(15)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .pulse_i(pulse),
        .event_valid_o(valid_a), .event_ready_i(ready), .pending_o(pend_a),
        .overflow_o(ovf_a), .width_err_o(err_a), .clear_i(clear)
    );

    edge_event_receiver #(.PulseWidth(4), .MaxPending(3)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .pulse_i(pulse),
        .event_valid_o(valid_b), .event_ready_i(ready), .pending_o(pend_b),
        .overflow_o(ovf_b), .width_err_o(err_b), .clear_i(clear)
    );

    // Reference model: events are pulse starts, widths are run lengths of
    // high samples, judged when the run ends.
    int m_pw[2] = '{1, 4};
    int m_mp[2] = '{15, 3};
    int m_pend[2];
    int m_run[2];
    bit m_prev[2];
    bit m_ovf[2];
    bit m_err[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_run[i] = 0; m_prev[i] = 0;
            m_ovf[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit rise, pop, set_err, set_ovf;
            rise = pulse && !m_prev[i];
            pop  = (m_pend[i] > 0) && ready;
            set_err = 0; set_ovf = 0;
            if (rise) m_run[i] = 1;
            else if (pulse) m_run[i] = m_run[i] + 1;
            else if (m_prev[i] && m_run[i] != m_pw[i]) set_err = 1;
            if (rise && !pop) begin
                if (m_pend[i] < m_mp[i]) m_pend[i] = m_pend[i] + 1;
                else set_ovf = 1;
            end else if (pop && !rise) begin
                m_pend[i] = m_pend[i] - 1;
            end
            m_err[i]  = set_err || (m_err[i] && !clear);
            m_ovf[i]  = set_ovf || (m_ovf[i] && !clear);
            m_prev[i] = pulse;
        end
    endtask

    // One clock: update the model from the current inputs, then sample 1 after the edge.
    task automatic step();
        if (rst_n) model_edge();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pulse(input int w, input int gap);
        pulse = 1'b1;
        repeat (w) step();
        pulse = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pulse = 1'b0; ready = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] obs(input int i);
        if (i == 0) return {valid_a, pend_a, ovf_a, err_a};
        return {valid_b, 2'b00, pend_b, ovf_b, err_b};
    endfunction

    function automatic logic [6:0] expv(input int i);
        return {(m_pend[i] != 0), 4'(m_pend[i]), m_ovf[i], m_err[i]};
    endfunction

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 7'd0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got=%b want=%b", i, obs(i), 7'd0);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        repeat (9) step();
        pulse = 1'b1;
        step();
        pulse = 1'b0;
        checks++;
        if ({valid_a, pend_a} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL single_capture got valid=%b pend=%0d want valid=1 pend=1", valid_a, pend_a);
        end
        repeat (9) step();
        checks++;
        if (pend_a !== 4'd1) begin
            errors++;
            $display("FAIL single_hold got pend=%0d want 1", pend_a);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        checks++;
        if ({valid_a, pend_a, err_a} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_pop got valid=%b pend=%0d err=%b want 0/0/0", valid_a, pend_a, err_a);
        end
        $display("test_single done pend_a=%0d", pend_a);
    endtask

    task automatic test_widths();
        int    widths[3] = '{4, 3, 6};
        logic  want_err[3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_pulse(widths[k], 2);
            checks++;
            if ({err_b, pend_b} !== {want_err[k], 2'(k + 1)}) begin
                errors++;
                $display("FAIL width_pulse%0d got err=%b pend=%0d want err=%b pend=%0d",
                         k, err_b, pend_b, want_err[k], k + 1);
            end
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({err_b, ovf_b, pend_b} !== {1'b0, 1'b0, 2'd3}) begin
            errors++;
            $display("FAIL width_clear got err=%b ovf=%b pend=%0d want 0/0/3", err_b, ovf_b, pend_b);
        end
        $display("test_widths done err_b=%b", err_b);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive_pulse(4, 2);
            checks++;
            if ({pend_b, ovf_b} !== {2'((k > 3) ? 3 : k), (k >= 4) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL overflow_pulse%0d got pend=%0d ovf=%b want pend=%0d ovf=%0d",
                         k, pend_b, ovf_b, (k > 3) ? 3 : k, k >= 4);
            end
        end
        $display("test_overflow done pend_b=%0d ovf_b=%b", pend_b, ovf_b);
    endtask

    // Continues from the full queue left by test_overflow.
    task automatic test_full_rise_pop();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL full_clear got ovf=%b want 0", ovf_b);
        end
        pulse = 1'b1; ready = 1'b1;
        step();
        pulse = 1'b0; ready = 1'b0;
        checks++;
        if ({pend_b, ovf_b} !== {2'd3, 1'b0}) begin
            errors++;
            $display("FAIL full_rise_pop got pend=%0d ovf=%b want pend=3 ovf=0", pend_b, ovf_b);
        end
        $display("test_full_rise_pop done pend_b=%0d", pend_b);
    endtask

    task automatic test_set_clear();
        do_reset();
        pulse = 1'b1;
        step(); step();
        pulse = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({err_a, err_b} !== 2'b11) begin
            errors++;
            $display("FAIL set_beats_clear got err_a=%b err_b=%b want 1/1", err_a, err_b);
        end
        $display("test_set_clear done");
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        pulse = 1'b1;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== 7'd0) begin
                errors++;
                $display("FAIL mid_reset_zero inst=%0d got=%b want=%b", i, obs(i), 7'd0);
            end
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({pend_a, pend_b} !== {4'd1, 2'd1}) begin
            errors++;
            $display("FAIL mid_reset_release got pend_a=%0d pend_b=%0d want 1/1", pend_a, pend_b);
        end
        pulse = 1'b0;
        step();
        $display("test_reset_mid_pulse done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pulse = (k % 2 == 0);
            step();
            checks++;
            if ({pend_a, ovf_a} !== {4'((k % 2 == 0) ? 1 : 0), 1'b0}) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got pend=%0d ovf=%b want pend=%0d ovf=0",
                         k, pend_a, ovf_a, (k % 2 == 0) ? 1 : 0);
            end
        end
        ready = 1'b0; pulse = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) pulse = ~pulse;
            ready = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 15) == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random cyc=%0d inst=%0d got=%b want=%b", c, i, obs(i), expv(i));
                end
            end
        end
        pulse = 1'b0; ready = 1'b0; clear = 1'b0;
        $display("test_random done mismatches=%0d", bad);
    endtask

    initial begin
        rst_n = 1'b0; pulse = 1'b0; ready = 1'b0; clear = 1'b0;
        test_reset();
        test_single();
        test_widths();
        test_overflow();
        test_full_rise_pop();
        test_set_clear();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
